logic_acc_unit: RTL and testbench
=================================

Name: logic_acc_unit

Overview:
- Parametrised, registered bitwise logic unit with a valid/ready handshake on both input and output.
- Generalises the plain 32-bit OR gate: WIDTH bits, 8 selectable bitwise ops, and an accumulate mode that OR-folds per-beat results across a multi-beat burst.
- Sits between operand-fetch and writeback stages of the ALU datapath. Also serves as the flag/mask merge engine for multi-word operands.

Parameters:
- WIDTH, 32, operand/result width in bits (>=1).
- CNT_W, 8, width of the beat counter; a burst saturates at 2^CNT_W-1 beats.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit accepts a beat this cycle
- op  input  3  bitwise op, sampled with the beat
- acc_mode  input  1  1 = beat is part of an accumulate burst
- last  input  1  final beat of a burst (ignored when acc_mode=0)
- i1  input  WIDTH  operand A
- i2  input  WIDTH  operand B
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out  output  WIDTH  result
- zero  output  1  out == 0, qualified by out_valid
- beats  output  CNT_W  beats folded into out (1 for single-op mode)

Behaviour:
- Reset is synchronous, active-low, in clk domain only. While rst_n=0 at a rising edge:
  - out_valid=0, out=0, zero=0, beats=0, acc register=0, FSM=IDLE.
  - in_ready=0 during reset cycles.
- Op encoding, computed bitwise over WIDTH:
  - 0 AND, 1 OR, 2 XOR, 3 NOR, 4 NAND, 5 XNOR, 6 i1&~i2, 7 pass i1.
- Accept rule: a beat is accepted when in_valid & in_ready at the clock edge.
  - in_ready = (state==IDLE & (!out_valid | out_ready)) | (state==ACC).
- Output handshake:
  - A result transfers when out_valid & out_ready.
  - out, zero and beats hold stable while out_valid=1 & out_ready=0.
- FSM states: IDLE, ACC, OUT.
- IDLE, accepted beat with acc_mode=0:
  - Next edge: out=f(op,i1,i2), beats=1, out_valid=1. Latency is 1 cycle. State stays IDLE.
  - Back-to-back: one result per cycle while out_ready=1.
- IDLE, accepted beat with acc_mode=1 & last=0:
  - acc=f(op,i1,i2), cnt=1, go to ACC.
- IDLE, accepted beat with acc_mode=1 & last=1:
  - Behaves as a one-beat burst: out=f, beats=1, out_valid=1, stay IDLE.
- ACC, each accepted beat:
  - acc = acc | f(op,i1,i2); op may differ per beat. cnt saturates at 2^CNT_W-1.
  - If last=1: out = the new acc value, beats = new cnt, out_valid=1, go to OUT.
- ACC, beat with acc_mode=0: treated as acc_mode=1 (the burst cannot be abandoned except by reset).
- OUT: in_ready=0. On an out_valid & out_ready transfer: out_valid=0, acc=0, go to IDLE.
  - The next beat may be accepted the cycle after the transfer.
- IDLE with out_valid=1 & out_ready=1 & accepted beat: the new result replaces the old one in the same edge, with no bubble.
- zero is registered together with out: zero = ~|out_next.
- in_valid=0 in ACC: the state holds, acc holds, and there is no timeout.
- Reset mid-burst or with a result pending discards the burst and the pending result. No partial output is produced.
- Widths:
  - out is exactly WIDTH bits; no carry or extension.
  - WIDTH=1 must work; zero is then ~out.

Test Plan:
- Single op, WIDTH=32, op=1, i1=0xF0F0_0000, i2=0x0000_0F0F, out_ready=1 -> next cycle out=0xF0F0_0F0F, beats=1, zero=0, out_valid=1 for exactly 1 cycle.
- All 8 ops with i1=0xFFFF_0000, i2=0xFF00_FF00 -> out is, in op order:
  - 0xFF00_0000, 0xFFFF_FF00, 0x00FF_FF00, 0x0000_00FF
  - 0x00FF_FFFF, 0xFF00_00FF, 0x00FF_0000, 0xFFFF_0000
- Accumulate burst of 3 beats, op=0 (AND), pairs (0x1,0x1), (0x2,0x3), (0x8,0x8) with last on beat 3:
  - in_ready=1 for all 3 beats; out_valid rises the cycle after beat 3.
  - out=0x0000_000B, beats=3.
- Backpressure: single op, out_ready=0 for 4 cycles -> out/zero/beats stable, in_ready=0, a second in_valid is not accepted. The result transfers when out_ready=1, then the second beat is accepted.
- Zero flag: op=2 (XOR), i1=i2=0xDEAD_BEEF -> out=0, zero=1.
  - Burst with op=0 and disjoint operands on every beat -> zero=1, beats=N.
- Reset mid-burst: rst_n=0 for 1 cycle after 2 of 4 beats -> out_valid=0, beats=0, FSM=IDLE.
  - A following single OR beat 0x1|0x2 yields out=0x3, beats=1, with no leftover acc.

Source files
------------

// File: rtl/logic_acc_unit_if.sv
// Operand/result handshake bundle for logic_acc_unit.
// master drives operands and accepts results; slave is the unit itself.
interface logic_acc_unit_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic             acc_mode;
  logic             last;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] i2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic [CNT_W-1:0] beats;

  modport master (
    output in_valid, op, acc_mode, last, i1, i2, out_ready,
    input  in_ready, out_valid, out, zero, beats
  );

  modport slave (
    input  in_valid, op, acc_mode, last, i1, i2, out_ready,
    output in_ready, out_valid, out, zero, beats
  );
endinterface

// File: rtl/logic_acc_unit.sv
// Registered bitwise logic unit with valid/ready on both sides.
// Single beats produce one result each; accumulate bursts OR-fold the
// per-beat results and emit one result on the last beat.
module logic_acc_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  logic_acc_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt_next;
  logic             fire_in;
  logic             fire_out;

  // in_ready is held low while reset is asserted, independent of state
  assign bus.in_ready = rst_n &
                        (((state == IDLE) & (~bus.out_valid | bus.out_ready)) |
                         (state == ACC));
  assign fire_in  = bus.in_valid & bus.in_ready;
  assign fire_out = bus.out_valid & bus.out_ready;

  // Per-beat bitwise function selected by op
  always_comb begin
    f = '0;
    case (bus.op)
      3'd0: f = bus.i1 & bus.i2;
      3'd1: f = bus.i1 | bus.i2;
      3'd2: f = bus.i1 ^ bus.i2;
      3'd3: f = ~(bus.i1 | bus.i2);
      3'd4: f = ~(bus.i1 & bus.i2);
      3'd5: f = ~(bus.i1 ^ bus.i2);
      3'd6: f = bus.i1 & ~bus.i2;
      3'd7: f = bus.i1;
      default: f = '0;
    endcase
  end

  // Fold value and saturating beat count for a beat accepted in ACC
  always_comb begin
    acc_next = acc | f;
    cnt_next = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  end

  // Control FSM with registered result, zero flag and beat count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      acc           <= '0;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      bus.out       <= '0;
      bus.zero      <= 1'b0;
      bus.beats     <= '0;
    end else begin
      case (state)
        IDLE: begin
          // a transfer and a new accept in the same edge replace the result
          if (fire_out) bus.out_valid <= 1'b0;
          if (fire_in) begin
            if (bus.acc_mode && !bus.last) begin
              acc   <= f;
              cnt   <= CNT_W'(1);
              state <= ACC;
            end else begin
              bus.out       <= f;
              bus.zero      <= ~|f;
              bus.beats     <= CNT_W'(1);
              bus.out_valid <= 1'b1;
            end
          end
        end
        ACC: begin
          // acc_mode is ignored here: a burst only ends on last or reset
          if (fire_in) begin
            acc <= acc_next;
            cnt <= cnt_next;
            if (bus.last) begin
              bus.out       <= acc_next;
              bus.zero      <= ~|acc_next;
              bus.beats     <= cnt_next;
              bus.out_valid <= 1'b1;
              state         <= OUT;
            end
          end
        end
        OUT: begin
          if (fire_out) begin
            bus.out_valid <= 1'b0;
            acc           <= '0;
            cnt           <= '0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_acc_unit.sv
// Directed self-checking bench for logic_acc_unit (WIDTH=32, CNT_W=8).
module tb_logic_acc_unit;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  logic_acc_unit_if #(.WIDTH(32), .CNT_W(8)) bus ();

  logic_acc_unit #(.WIDTH(32), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for exactly one edge, then drop in_valid
  task automatic beat(input logic [2:0] o, input logic am, input logic lst,
                      input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.acc_mode = am;
    bus.last     = lst;
    bus.i1       = a;
    bus.i2       = b;
    tick();
    bus.in_valid = 1'b0;
  endtask

  logic [31:0] exp_ops [8];

  initial begin
    errors = 0;
    checks = 0;
    exp_ops = '{32'hFF00_0000, 32'hFFFF_FF00, 32'h00FF_FF00, 32'h0000_00FF,
                32'h00FF_FFFF, 32'hFF00_00FF, 32'h00FF_0000, 32'hFFFF_0000};

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.op       = 3'd0;
    bus.acc_mode = 1'b0;
    bus.last     = 1'b0;
    bus.i1       = '0;
    bus.i2       = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_in_ready",  32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out",       bus.out, 32'd0);
    chk("rst_zero",      32'(bus.zero), 32'd0);
    chk("rst_beats",     32'(bus.beats), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single OR beat, one-cycle latency, valid for exactly one cycle
    beat(3'd1, 1'b0, 1'b0, 32'hF0F0_0000, 32'h0000_0F0F);
    chk("or_valid", 32'(bus.out_valid), 32'd1);
    chk("or_out",   bus.out, 32'hF0F0_0F0F);
    chk("or_beats", 32'(bus.beats), 32'd1);
    chk("or_zero",  32'(bus.zero), 32'd0);
    tick();
    chk("or_valid_drop", 32'(bus.out_valid), 32'd0);

    // All eight ops back-to-back
    bus.in_valid = 1'b1;
    bus.acc_mode = 1'b0;
    bus.i1 = 32'hFFFF_0000;
    bus.i2 = 32'hFF00_FF00;
    for (int k = 0; k < 8; k++) begin
      bus.op = 3'(k);
      tick();
      chk($sformatf("op%0d_out", k), bus.out, exp_ops[k]);
      chk($sformatf("op%0d_valid", k), 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    tick();

    // Three-beat AND burst: 1 | 2 | 8 = 0xB
    bus.in_valid = 1'b1; bus.op = 3'd0; bus.acc_mode = 1'b1; bus.last = 1'b0;
    bus.i1 = 32'h1; bus.i2 = 32'h1;
    #1 chk("acc_b1_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("acc_b1_valid", 32'(bus.out_valid), 32'd0);
    bus.i1 = 32'h2; bus.i2 = 32'h3;
    chk("acc_b2_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.i1 = 32'h8; bus.i2 = 32'h8; bus.last = 1'b1;
    chk("acc_b3_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("acc_valid", 32'(bus.out_valid), 32'd1);
    chk("acc_out",   bus.out, 32'h0000_000B);
    chk("acc_beats", 32'(bus.beats), 32'd3);
    chk("acc_out_state_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("acc_drained", 32'(bus.out_valid), 32'd0);

    // Backpressure: result held, second beat waits, then same-edge replace
    bus.out_ready = 1'b0;
    beat(3'd1, 1'b0, 1'b0, 32'h0000_00F0, 32'h0000_0F00);
    bus.in_valid = 1'b1; bus.op = 3'd7; bus.i1 = 32'h0000_1234; bus.i2 = 32'h0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("bp%0d_ready", c), 32'(bus.in_ready), 32'd0);
      tick();
      chk($sformatf("bp%0d_out", c), bus.out, 32'h0000_0FF0);
      chk($sformatf("bp%0d_valid", c), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp%0d_beats", c), 32'(bus.beats), 32'd1);
      chk($sformatf("bp%0d_zero", c), 32'(bus.zero), 32'd0);
    end
    bus.out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_second_out", bus.out, 32'h0000_1234);
    chk("bp_second_valid", 32'(bus.out_valid), 32'd1);
    tick();
    chk("bp_drained", 32'(bus.out_valid), 32'd0);

    // Zero flag from XOR of equal operands
    beat(3'd2, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    chk("xor_out",  bus.out, 32'd0);
    chk("xor_zero", 32'(bus.zero), 32'd1);
    tick();

    // Burst of disjoint ANDs folds to zero over 4 beats
    beat(3'd0, 1'b1, 1'b0, 32'h0000_0001, 32'h0000_0002);
    beat(3'd0, 1'b1, 1'b0, 32'h0000_00F0, 32'h0000_000F);
    beat(3'd0, 1'b1, 1'b0, 32'h0000_FF00, 32'h0000_00FF);
    beat(3'd0, 1'b1, 1'b1, 32'hA5A5_5A5A, 32'h5A5A_A5A5);
    chk("dis_out",   bus.out, 32'd0);
    chk("dis_zero",  32'(bus.zero), 32'd1);
    chk("dis_beats", 32'(bus.beats), 32'd4);
    tick();

    // One-beat burst (acc_mode=1, last=1) from IDLE
    beat(3'd6, 1'b1, 1'b1, 32'h0000_00FF, 32'h0000_000F);
    chk("one_burst_out",   bus.out, 32'h0000_00F0);
    chk("one_burst_beats", 32'(bus.beats), 32'd1);
    tick();

    // Reset after 2 of 4 burst beats discards everything
    beat(3'd1, 1'b1, 1'b0, 32'h0000_00F0, 32'h0);
    beat(3'd1, 1'b1, 1'b0, 32'h0000_0F00, 32'h0);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_beats", 32'(bus.beats), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    #1 chk("mid_rst_idle", 32'(bus.in_ready), 32'd1);
    beat(3'd1, 1'b0, 1'b0, 32'h1, 32'h2);
    chk("post_rst_out",   bus.out, 32'h3);
    chk("post_rst_beats", 32'(bus.beats), 32'd1);
    tick();

    // Fresh burst shows no leftover acc; acc_mode=0 inside ACC still folds
    beat(3'd1, 1'b1, 1'b0, 32'h0, 32'h0);
    beat(3'd1, 1'b0, 1'b1, 32'h4, 32'h0);
    chk("clean_acc_out",   bus.out, 32'h4);
    chk("clean_acc_beats", 32'(bus.beats), 32'd2);
    tick();

    // Beat counter saturates at 255 over a 300-beat burst
    for (int i = 0; i < 300; i++) begin
      bus.in_valid = 1'b1; bus.op = 3'd7; bus.acc_mode = 1'b1;
      bus.last = (i == 299); bus.i1 = 32'(i); bus.i2 = 32'h0;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("sat_valid", 32'(bus.out_valid), 32'd1);
    chk("sat_beats", 32'(bus.beats), 32'd255);
    chk("sat_out",   bus.out, 32'h0000_01FF);
    tick();
    chk("sat_drained", 32'(bus.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
